// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: default bundle widths, field offsets,
// bubble constants and the per-edge action encoding used by the stage registers.
package pipe_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned PIPE_CTRL_W = 24;
    localparam int unsigned PIPE_DATA_W = 7 * WORD_W;
    localparam int unsigned MAX_SQUASH  = 7;

    // Control bundle layout
    localparam int unsigned CTRL_ALUOP_LSB    = 0;
    localparam int unsigned CTRL_ALUOP_W      = 4;
    localparam int unsigned CTRL_REGWRITE_BIT = 4;
    localparam int unsigned CTRL_MEMREAD_BIT  = 5;
    localparam int unsigned CTRL_MEMWRITE_BIT = 6;

    // Data bundle layout: instruction word is the sixth 32-bit field
    localparam int unsigned DATA_INSTR_LSB = 5 * WORD_W;

    localparam logic [PIPE_CTRL_W-1:0] CTRL_BUBBLE = '0;
    localparam logic [PIPE_DATA_W-1:0] DATA_BUBBLE = '0;

    typedef enum logic [2:0] {
        ACT_FLUSH,
        ACT_SQUASH,
        ACT_HOLD,
        ACT_JUMP,
        ACT_LOAD
    } stage_act_e;

endpackage

// File: rtl/id_ex_stage_reg_squash_counter.sv
// Load/decrement/clear bubble counter with a nonzero flag; shared by stage registers.
module squash_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             active_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active_o = (cnt_q != '0);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall, flush and post-jump squash bubbles.
// Optional statistics outputs enabled by defining ID_EX_STAGE_STATS_EN.
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W        = PIPE_CTRL_W,
    parameter int unsigned DATA_W        = PIPE_DATA_W,
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned CNT_W         = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic              InJump,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    output logic              OutJump,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
`ifdef ID_EX_STAGE_STATS_EN
    output logic [15:0]       BubbleCount,
    output logic [15:0]       StallCount,
`endif
    output logic              SquashActive
);

    stage_act_e        act;
    logic              valid_q, valid_d;
    logic              jump_q, jump_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              squash_active;
    logic              cnt_load;

    // Priority: flush > pending squash > stall > accepted jump > plain load
    always_comb begin
        act = ACT_LOAD;
        if (Flush) begin
            act = ACT_FLUSH;
        end else if (squash_active) begin
            act = ACT_SQUASH;
        end else if (Stall) begin
            act = ACT_HOLD;
        end else if (InValid && InJump) begin
            act = ACT_JUMP;
        end
    end

    always_comb begin
        valid_d = valid_q;
        jump_d  = jump_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        unique case (act)
            ACT_FLUSH, ACT_SQUASH: begin
                valid_d = 1'b0;
                jump_d  = 1'b0;
                ctrl_d  = CTRL_W'(CTRL_BUBBLE);
                data_d  = DATA_W'(DATA_BUBBLE);
            end
            ACT_HOLD: begin
            end
            default: begin
                valid_d = InValid;
                jump_d  = InValid & InJump;
                ctrl_d  = InCtrl;
                data_d  = InData;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            jump_q  <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            jump_q  <= jump_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign cnt_load = (act == ACT_JUMP) && (SQUASH_CYCLES != 0);

    squash_counter #(
        .CNT_W (CNT_W)
    ) u_squash (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .clear_i    (act == ACT_FLUSH),
        .load_i     (cnt_load),
        .dec_i      (act == ACT_SQUASH),
        .load_val_i (CNT_W'(SQUASH_CYCLES)),
        .active_o   (squash_active)
    );

    assign OutValid     = valid_q;
    assign OutJump      = jump_q;
    assign OutCtrl      = ctrl_q;
    assign OutData      = data_q;
    assign SquashActive = squash_active;

`ifdef ID_EX_STAGE_STATS_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (((act == ACT_FLUSH) || (act == ACT_SQUASH)) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if ((act == ACT_HOLD) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign BubbleCount = bubble_cnt_q;
    assign StallCount  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: vector table plus multi-cycle sequences.
// Statistics checks compile in when ID_EX_STAGE_STATS_EN is defined.
module tb_id_ex_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned CW = PIPE_CTRL_W;
    localparam int unsigned DW = PIPE_DATA_W;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Stall = 1'b0, Flush = 1'b0, InValid = 1'b0, InJump = 1'b0;
    logic [CW-1:0] InCtrl = '0;
    logic [DW-1:0] InData = '0;

    logic          OutValid, OutJump, SquashActive;
    logic [CW-1:0] OutCtrl;
    logic [DW-1:0] OutData;
    logic          OutValid0, OutJump0, SquashActive0;
    logic [CW-1:0] OutCtrl0;
    logic [DW-1:0] OutData0;
`ifdef ID_EX_STAGE_STATS_EN
    logic [15:0]   BubbleCount, StallCount, BubbleCount0, StallCount0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    id_ex_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .SQUASH_CYCLES(2), .CNT_W(3)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .InJump(InJump), .InCtrl(InCtrl), .InData(InData),
        .OutValid(OutValid), .OutJump(OutJump), .OutCtrl(OutCtrl), .OutData(OutData),
`ifdef ID_EX_STAGE_STATS_EN
        .BubbleCount(BubbleCount), .StallCount(StallCount),
`endif
        .SquashActive(SquashActive)
    );

    id_ex_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .SQUASH_CYCLES(0), .CNT_W(3)
    ) dut0 (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .InValid(InValid), .InJump(InJump), .InCtrl(InCtrl), .InData(InData),
        .OutValid(OutValid0), .OutJump(OutJump0), .OutCtrl(OutCtrl0), .OutData(OutData0),
`ifdef ID_EX_STAGE_STATS_EN
        .BubbleCount(BubbleCount0), .StallCount(StallCount0),
`endif
        .SquashActive(SquashActive0)
    );

    typedef struct {
        logic        stall, flush, valid, jump;
        logic [23:0] ctrl;
        logic [31:0] word;
        logic        e_valid, e_jump;
        logic [23:0] e_ctrl;
        logic [31:0] e_word;
        logic        e_sq;
    } vec_t;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic j,
                         input logic [23:0] c, input logic [31:0] w);
        Stall   = st;
        Flush   = fl;
        InValid = v;
        InJump  = j;
        InCtrl  = c;
        InData  = {7{w}};
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    vec_t vecs[13];

    initial begin
        // stall flush valid jump ctrl word | e_valid e_jump e_ctrl e_word e_sq
        vecs[0]  = '{0,0,1,0, 24'h000111, 32'h000000A1, 1,0, 24'h000111, 32'h000000A1, 0};
        vecs[1]  = '{0,0,0,0, 24'h000005, 32'h000000B2, 0,0, 24'h000005, 32'h000000B2, 0};
        vecs[2]  = '{0,0,0,1, 24'h000006, 32'h000000C3, 0,0, 24'h000006, 32'h000000C3, 0};
        vecs[3]  = '{0,0,1,1, 24'h000111, 32'h00001000, 1,1, 24'h000111, 32'h00001000, 1};
        vecs[4]  = '{0,0,1,0, 24'h000022, 32'h00000022, 0,0, 24'h000000, 32'h00000000, 1};
        vecs[5]  = '{1,0,1,0, 24'h000033, 32'h00000033, 0,0, 24'h000000, 32'h00000000, 0};
        vecs[6]  = '{0,0,1,0, 24'h000044, 32'h00000044, 1,0, 24'h000044, 32'h00000044, 0};
        vecs[7]  = '{1,0,1,0, 24'h000055, 32'h00000055, 1,0, 24'h000044, 32'h00000044, 0};
        vecs[8]  = '{1,1,1,0, 24'h000066, 32'h00000066, 0,0, 24'h000000, 32'h00000000, 0};
        vecs[9]  = '{1,0,1,1, 24'h000077, 32'h00000077, 0,0, 24'h000000, 32'h00000000, 0};
        vecs[10] = '{0,0,1,1, 24'h000077, 32'h00000077, 1,1, 24'h000077, 32'h00000077, 1};
        vecs[11] = '{0,1,1,0, 24'h000080, 32'h00000080, 0,0, 24'h000000, 32'h00000000, 0};
        vecs[12] = '{0,0,1,0, 24'h000088, 32'h00000088, 1,0, 24'h000088, 32'h00000088, 0};

        tick();
        tick();
        Reset = 1'b0;

        chk("reset_valid", 256'(OutValid), 256'(0));
        chk("reset_jump",  256'(OutJump), 256'(0));
        chk("reset_ctrl",  256'(OutCtrl), 256'(0));
        chk("reset_data",  256'(OutData), 256'(0));
        chk("reset_sq",    256'(SquashActive), 256'(0));

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].jump, vecs[i].ctrl, vecs[i].word);
            tick();
            chk($sformatf("v%0d_valid", i), 256'(OutValid), 256'(vecs[i].e_valid));
            chk($sformatf("v%0d_jump", i),  256'(OutJump),  256'(vecs[i].e_jump));
            chk($sformatf("v%0d_ctrl", i),  256'(OutCtrl),  256'(vecs[i].e_ctrl));
            chk($sformatf("v%0d_data", i),  256'(OutData),  256'({7{vecs[i].e_word}}));
            chk($sformatf("v%0d_sq", i),    256'(SquashActive), 256'(vecs[i].e_sq));
            chk($sformatf("v%0d_sq0", i),   256'(SquashActive0), 256'(0));
        end

        // Asynchronous reset between edges
        drive(0, 0, 1, 0, 24'hABCDEF, 32'hFFFFFFFF);
        tick();
        chk("ar_cap_ctrl", 256'(OutCtrl), 256'(24'hABCDEF));
        #2 Reset = 1'b1;
        #1;
        chk("ar_valid", 256'(OutValid), 256'(0));
        chk("ar_ctrl",  256'(OutCtrl), 256'(0));
        chk("ar_data",  256'(OutData), 256'(0));
        Reset = 1'b0;

        // Reset mid-squash leaves no pending bubbles
        drive(0, 0, 1, 1, 24'h000123, 32'h00000123);
        tick();
        chk("rs_sq_on", 256'(SquashActive), 256'(1));
        #2 Reset = 1'b1;
        #1;
        chk("rs_sq_off", 256'(SquashActive), 256'(0));
        chk("rs_jump",   256'(OutJump), 256'(0));
        Reset = 1'b0;
        drive(0, 0, 1, 0, 24'h000099, 32'h00000099);
        tick();
        chk("rs_next_valid", 256'(OutValid), 256'(1));
        chk("rs_next_ctrl",  256'(OutCtrl), 256'(24'h000099));

        // Stall hold for three cycles, release one cycle later
        drive(0, 0, 1, 0, 24'h000010, 32'h00001234);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 24'h000020 + 24'(k), 32'hDEAD0000 + 32'(k));
            tick();
            chk($sformatf("st_hold%0d", k), 256'(OutData[31:0]), 256'(32'h00001234));
        end
        drive(0, 0, 1, 0, 24'h000030, 32'h00005678);
        chk("st_pre_release", 256'(OutData[31:0]), 256'(32'h00001234));
        tick();
        chk("st_release", 256'(OutData), 256'({7{32'h00005678}}));

        // SQUASH_CYCLES=0 never squashes
        drive(0, 0, 1, 1, 24'h000041, 32'h00000041);
        tick();
        chk("z_sq_main", 256'(SquashActive), 256'(1));
        chk("z_sq_zero", 256'(SquashActive0), 256'(0));
        chk("z_jump0",   256'(OutJump0), 256'(1));
        drive(0, 0, 1, 0, 24'h000042, 32'h00000042);
        tick();
        chk("z_next_valid0", 256'(OutValid0), 256'(1));
        chk("z_next_ctrl0",  256'(OutCtrl0), 256'(24'h000042));
        chk("z_next_main",   256'(OutValid), 256'(0));
        tick();
        tick();

`ifdef ID_EX_STAGE_STATS_EN
        Reset = 1'b1;
        #1 Reset = 1'b0;
        chk("stat_reset_b", 256'(BubbleCount), 256'(0));
        chk("stat_reset_s", 256'(StallCount), 256'(0));
        for (int n = 0; n < 2; n++) begin
            drive(0, 0, 1, 1, 24'h000001, 32'h00000001);
            tick();
            drive(0, 0, 1, 0, 24'h000002, 32'h00000002);
            tick();
            tick();
        end
        drive(0, 1, 1, 0, 24'h000003, 32'h00000003);
        tick();
        for (int n = 0; n < 5; n++) begin
            drive(1, 0, 1, 0, 24'h000004, 32'h00000004);
            tick();
        end
        chk("stat_bubbles", 256'(BubbleCount), 256'(5));
        chk("stat_stalls",  256'(StallCount), 256'(5));
        drive(0, 1, 0, 0, 24'h0, 32'h0);
        for (int n = 0; n < 65529; n++) tick();
        chk("stat_fffe", 256'(BubbleCount), 256'(16'hFFFE));
        for (int n = 0; n < 3; n++) tick();
        chk("stat_sat", 256'(BubbleCount), 256'(16'hFFFF));
        drive(0, 0, 0, 0, 24'h0, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
